// File: rtl/fpu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : fpu_issue_queue
// Purpose  : Command FIFO in front of a single-issue FPU. Commands are
//            launched one at a time in push order; each result (or a timeout
//            marker) is returned with the tag of the command that produced it.
// Ports    : clk            - clock, all state updates on the rising edge
//            rst_n          - asynchronous active-low reset
//            i_cmd_*        - command push channel {opcode,a,b,tag}
//            o_cmd_ready    - FIFO has room (count < DEPTH)
//            o_fpu_start    - one-cycle launch pulse
//            o_fpu_opcode/a/b - operands of the launched command
//            i_fpu_z/error  - FPU result; i_fpu_done high means FPU idle
//            o_rsp_*        - response channel, held until i_rsp_ready
//            o_count        - FIFO occupancy (includes the in-flight command)
// Revision : 1.0 - initial release
// ============================================================================
module fpu_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [1:0]               i_cmd_opcode,
    input  logic [31:0]              i_cmd_a,
    input  logic [31:0]              i_cmd_b,
    input  logic [3:0]               i_cmd_tag,
    output logic                     o_fpu_start,
    output logic [1:0]               o_fpu_opcode,
    output logic [31:0]              o_fpu_a,
    output logic [31:0]              o_fpu_b,
    input  logic [31:0]              i_fpu_z,
    input  logic [2:0]               i_fpu_error,
    input  logic                     i_fpu_done,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [31:0]              o_rsp_z,
    output logic [2:0]               o_rsp_error,
    output logic [3:0]               o_rsp_tag,
    output logic                     o_rsp_timeout,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_WW = $clog2(TIMEOUT + 1);
    localparam int c_EW = 2 + 32 + 32 + 4;

    localparam logic [c_AW:0]   c_CNT_FULL = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE  = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
    localparam logic [c_WW-1:0] c_WAIT_ONE = c_WW'(1);
    // Last wait cycle: the counter holds cycles already spent waiting.
    localparam logic [c_WW-1:0] c_WAIT_LAST = c_WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESP      = 3'd4
    } t_state;

    t_state            r_state;
    t_state            w_state_nxt;
    logic [c_EW-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic [c_WW-1:0]   r_wait;
    logic [3:0]        r_tag;
    logic [1:0]        r_fpu_opcode;
    logic [31:0]       r_fpu_a;
    logic [31:0]       r_fpu_b;
    logic [31:0]       r_rsp_z;
    logic [2:0]        r_rsp_error;
    logic              r_rsp_timeout;

    logic              w_push;
    logic              w_pop;
    logic              w_launch;
    logic              w_tmo;
    logic [c_EW-1:0]   w_head;

    assign o_cmd_ready   = (r_count != c_CNT_FULL);
    assign w_push        = i_cmd_valid && o_cmd_ready;
    assign w_head        = r_mem[r_rd_ptr];

    assign o_fpu_start   = (r_state == S_LAUNCH);
    assign o_rsp_valid   = (r_state == S_RESP);
    assign o_fpu_opcode  = r_fpu_opcode;
    assign o_fpu_a       = r_fpu_a;
    assign o_fpu_b       = r_fpu_b;
    assign o_rsp_z       = r_rsp_z;
    assign o_rsp_error   = r_rsp_error;
    assign o_rsp_tag     = r_tag;
    assign o_rsp_timeout = r_rsp_timeout;
    assign o_count       = r_count;

    // The head stays in the FIFO while in flight and is popped only when the
    // response is captured, so a full queue counts the launched command too.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_pop       = 1'b0;
        w_tmo       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if ((r_count != '0) && i_fpu_done) begin
                    w_state_nxt = S_LAUNCH;
                    w_launch    = 1'b1;
                end
            end
            S_LAUNCH: begin
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (r_wait == c_WAIT_LAST) begin
                    w_state_nxt = S_RESP;
                    w_pop       = 1'b1;
                    w_tmo       = 1'b1;
                end else if (!i_fpu_done) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // A real completion on the final wait cycle beats the timeout.
                if (i_fpu_done) begin
                    w_state_nxt = S_RESP;
                    w_pop       = 1'b1;
                end else if (r_wait == c_WAIT_LAST) begin
                    w_state_nxt = S_RESP;
                    w_pop       = 1'b1;
                    w_tmo       = 1'b1;
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_cmd_opcode, i_cmd_a, i_cmd_b, i_cmd_tag};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_wait        <= '0;
            r_tag         <= '0;
            r_fpu_opcode  <= '0;
            r_fpu_a       <= '0;
            r_fpu_b       <= '0;
            r_rsp_z       <= '0;
            r_rsp_error   <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            if (r_state == S_LAUNCH) begin
                r_wait <= '0;
            end else if ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE)) begin
                r_wait <= r_wait + c_WAIT_ONE;
            end

            if (w_launch) begin
                {r_fpu_opcode, r_fpu_a, r_fpu_b, r_tag} <= w_head;
            end

            if (w_pop) begin
                r_rsp_z       <= w_tmo ? 32'd0 : i_fpu_z;
                r_rsp_error   <= w_tmo ? 3'd0  : i_fpu_error;
                r_rsp_timeout <= w_tmo;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/fpu_issue_queue.md
FPU_ISSUE_QUEUE -- requirements
Module: fpu_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4 (power of two, >=2): command FIFO entries.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles spent waiting on the FPU per command.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  upstream command valid.
REQ-006 cmd_ready  out  1  queue can accept; high when count < DEPTH.
REQ-007 cmd_opcode  in  2  00 add, 01 sub, 10 mul, 11 div.
REQ-008 cmd_a, cmd_b  in  32  IEEE-754 single operands.
REQ-009 cmd_tag  in  4  opaque ID, returned with the result.
REQ-010 fpu_start  out  1  one-cycle launch pulse to the FPU.
REQ-011 fpu_opcode  out  2; fpu_a, fpu_b  out  32  operands to the FPU.
REQ-012 fpu_z  in  32; fpu_error  in  3; fpu_done  in  1 (high = FPU idle).
REQ-013 rsp_valid  out  1; rsp_ready  in  1  result handshake.
REQ-014 rsp_z  out  32; rsp_error  out  3; rsp_tag  out  4; rsp_timeout  out  1.
REQ-015 count  out  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 A push SHALL occur on a rising edge with cmd_valid && cmd_ready; {opcode,a,b,tag} written at the write pointer, pointer wraps modulo DEPTH.
REQ-017 When count == DEPTH, cmd_ready SHALL be 0 and cmd_valid SHALL have no effect.
REQ-018 Push and pop in the same cycle SHALL leave count unchanged and update both pointers.
REQ-019 The FSM SHALL have states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP.
REQ-020 IDLE -> LAUNCH when count != 0 and fpu_done == 1; otherwise remain in IDLE.
REQ-021 On the IDLE -> LAUNCH edge, the head entry SHALL be copied into fpu_opcode/fpu_a/fpu_b/an internal tag register; these SHALL stay stable until the next LAUNCH.
REQ-022 LAUNCH: fpu_start = 1 for exactly that one cycle; unconditional -> WAIT_BUSY.
REQ-023 WAIT_BUSY -> WAIT_DONE when fpu_done == 0.
REQ-024 WAIT_DONE -> RESP when fpu_done == 1; on that edge capture rsp_z <= fpu_z, rsp_error <= fpu_error, rsp_timeout <= 0, and pop the FIFO head.
REQ-025 A wait counter SHALL clear on entry to WAIT_BUSY and increment every cycle in WAIT_BUSY/WAIT_DONE; on reaching TIMEOUT -> RESP with rsp_z = 0, rsp_error = 0, rsp_timeout = 1, and head popped.
REQ-026 RESP: rsp_valid = 1, rsp_tag = launched tag; payload SHALL remain stable until rsp_ready; RESP -> IDLE on rsp_valid && rsp_ready.
REQ-027 rsp_valid SHALL be 0 in every state except RESP; fpu_start SHALL be 0 in every state except LAUNCH.
REQ-028 Latency: command pushed into an empty queue at edge N with FSM in IDLE and fpu_done = 1 SHALL see fpu_start high in the cycle after edge N+1.
REQ-029 Commands SHALL complete and be returned in push order; exactly one command in flight at the FPU.
REQ-030 Pushes SHALL continue to be accepted during LAUNCH/WAIT/RESP while not full.

Reset
REQ-031 rst low SHALL immediately (asynchronously) force state IDLE, pointers 0, count 0, wait counter 0.
REQ-032 Reset values: cmd_ready 1 (once rst is deasserted), fpu_start 0, fpu_opcode 0, fpu_a 0, fpu_b 0, rsp_valid 0, rsp_z 0, rsp_error 0, rsp_tag 0, rsp_timeout 0.
REQ-033 Reset asserted mid-operation SHALL discard queued and in-flight commands; no response for them SHALL ever appear.

Verification
REQ-034 Push mul a=0x41280000 b=0x40600000 tag=3, FPU model -> one fpu_start pulse at REQ-028 timing; rsp_z=0x42130000, rsp_tag=3, rsp_timeout=0.
REQ-035 Push 5 commands back-to-back with fpu_done held 0 -> cmd_ready drops after the 4th push, count=4, no fpu_start issued.
REQ-036 Push add(0x3F800000,0x40000000,tag=1), sub(same,tag=2), rsp_ready low 10 cycles -> rsp payload stable; responses 0x40400000 tag 1, then 0xBF800000 tag 2, in order.
REQ-037 FPU model never drops fpu_done after fpu_start -> after TIMEOUT cycles rsp_timeout=1, rsp_z=0; next queued command then launches.
REQ-038 Assert rst low while in WAIT_DONE with 2 queued -> outputs take reset values immediately; after release with no pushes, no rsp_valid and no fpu_start.
REQ-039 Push on the same edge as a pop with count=DEPTH-1 -> count unchanged, pointers wrap correctly over 3*DEPTH commands, all tags returned in order.
